// File: rtl/fir_pkg.sv
// Shared encodings for the FIR MAC sequencer: ALU opcodes, operand
// select codes and the sequencer state type.
package fir_pkg;

    localparam logic [1:0] OP_NORM = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    localparam logic [1:0] A_DMEM  = 2'd0;
    localparam logic [1:0] A_REGF  = 2'd1;
    localparam logic [1:0] A_SELF  = 2'd2;
    localparam logic [1:0] A_ACC   = 2'd3;

    localparam logic [1:0] B_CMEM  = 2'd0;
    localparam logic [1:0] B_SELF  = 2'd1;
    localparam logic [1:0] B_ACC   = 2'd2;
    localparam logic [1:0] B_ZERO  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_MDRAIN,
        S_ACC,
        S_SPILL,
        S_FOLD,
        S_NORM
    } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Request inputs and memory/ALU control outputs of the FIR MAC sequencer.
interface fir_mac_sequencer_if #(
    parameter int TAPS    = 64,
    parameter int ADD_LAT = 5,
    parameter int AW      = $clog2(TAPS + ADD_LAT),
    parameter int DW      = $clog2(TAPS)
);
    logic          sample_valid;
    logic          cload;
    logic [DW-1:0] caddr;
    logic          ovr_clr;
    logic          dmem_we;
    logic [DW-1:0] dmem_waddr;
    logic [DW-1:0] dmem_raddr;
    logic          cmem_we;
    logic [DW-1:0] cmem_waddr;
    logic [DW-1:0] cmem_raddr;
    logic          regf_we;
    logic [AW-1:0] regf_waddr;
    logic [AW-1:0] regf_raddr;
    logic          acc_we;
    logic          alu_issue;
    logic [1:0]    alu_opcode;
    logic [1:0]    alu_a_sel;
    logic [1:0]    alu_b_sel;
    logic          busy;
    logic          dout_valid;
    logic          overrun;
    logic          coef_err;

    modport master (
        input  sample_valid, cload, caddr, ovr_clr,
        output dmem_we, dmem_waddr, dmem_raddr, cmem_we, cmem_waddr, cmem_raddr,
               regf_we, regf_waddr, regf_raddr, acc_we, alu_issue, alu_opcode,
               alu_a_sel, alu_b_sel, busy, dout_valid, overrun, coef_err
    );

    modport slave (
        output sample_valid, cload, caddr, ovr_clr,
        input  dmem_we, dmem_waddr, dmem_raddr, cmem_we, cmem_waddr, cmem_raddr,
               regf_we, regf_waddr, regf_raddr, acc_we, alu_issue, alu_opcode,
               alu_a_sel, alu_b_sel, busy, dout_valid, overrun, coef_err
    );
endinterface

// File: rtl/fir_tag_pipe.sv
// Fixed-depth delay line carrying a valid bit and a REGF write address,
// used to tag multiplier results with their destination.
module fir_tag_pipe #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic         clk_fast,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_addr,
    output logic         out_valid,
    output logic [W-1:0] out_addr
);
    logic [DEPTH-1:0]        v_q, v_d;
    logic [DEPTH-1:0][W-1:0] a_q, a_d;

    // Shift every stage one step toward the output.
    always_comb begin
        v_d    = v_q;
        a_d    = a_q;
        v_d[0] = in_valid;
        a_d[0] = in_addr;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            v_d[i] = v_q[i-1];
            a_d[i] = a_q[i-1];
        end
    end

    // Pipeline registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            a_q <= '0;
        end else begin
            v_q <= v_d;
            a_q <= a_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_addr  = a_q[DEPTH-1];
endmodule

// File: rtl/fir_mac_sequencer.sv
// Single-clock control sequencer for the time-multiplexed FP FIR filter:
// multiply pass, accumulate pass, spill, fold of the interleaved partial
// sums and a final normalise, one sequence per accepted sample.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS    = 64,
    parameter int MUL_LAT = 4,
    parameter int ADD_LAT = 5,
    parameter int AW      = $clog2(TAPS + ADD_LAT)
) (
    input logic               clk_fast,
    input logic               rst_n,
    fir_mac_sequencer_if.master bus
);
    localparam int DW       = $clog2(TAPS);
    localparam int KW       = 16;
    localparam int FOLD_CYC = (ADD_LAT - 1) * ADD_LAT;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] wr_ptr_q, wr_ptr_d, newest_q, newest_d;
    logic          overrun_q, overrun_d, coef_err_q, coef_err_d;
    logic          issue_q, issue_d, spill_we_q, spill_we_d;
    logic          acc_we_q, acc_we_d, dout_valid_q, dout_valid_d;
    logic [1:0]    opcode_q, opcode_d, a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic [DW-1:0] dmem_raddr_q, dmem_raddr_d, cmem_raddr_q, cmem_raddr_d;
    logic [AW-1:0] regf_raddr_q, regf_raddr_d, spill_waddr_q, spill_waddr_d;
    logic          idle, tag_valid;
    logic [AW-1:0] tag_addr;
    int            rd_diff, fold_step;

    assign idle = (state_q == S_IDLE);

    // Next state, counters and sticky flags; outputs are then decoded from
    // the next state so that registering them keeps them aligned with it.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q + KW'(1);
        wr_ptr_d   = wr_ptr_q;
        newest_d   = newest_q;
        overrun_d  = (!idle && bus.sample_valid) || (overrun_q && !bus.ovr_clr);
        coef_err_d = (!idle && bus.cload) || (coef_err_q && !bus.ovr_clr);
        case (state_q)
            S_IDLE: begin
                k_d = '0;
                if (bus.sample_valid) begin
                    state_d  = S_MUL;
                    newest_d = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == DW'(TAPS - 1)) ? '0 : wr_ptr_q + DW'(1);
                end
            end
            S_MUL:    if (k_q == KW'(TAPS - 1))    begin state_d = S_MDRAIN; k_d = '0; end
            S_MDRAIN: if (k_q == KW'(MUL_LAT - 1)) begin state_d = S_ACC;    k_d = '0; end
            S_ACC:    if (k_q == KW'(TAPS - 1))    begin state_d = S_SPILL;  k_d = '0; end
            S_SPILL:  if (k_q == KW'(ADD_LAT - 1)) begin
                state_d = (ADD_LAT > 1) ? S_FOLD : S_NORM;
                k_d     = '0;
            end
            S_FOLD:   if (k_q == KW'(FOLD_CYC - 1)) begin state_d = S_NORM; k_d = '0; end
            S_NORM:   if (k_q == KW'(ADD_LAT))      begin state_d = S_IDLE; k_d = '0; end
            default:  begin state_d = S_IDLE; k_d = '0; end
        endcase

        issue_d       = 1'b0;
        opcode_d      = '0;
        a_sel_d       = '0;
        b_sel_d       = '0;
        dmem_raddr_d  = '0;
        cmem_raddr_d  = '0;
        regf_raddr_d  = '0;
        spill_we_d    = 1'b0;
        spill_waddr_d = '0;
        acc_we_d      = 1'b0;
        dout_valid_d  = 1'b0;
        rd_diff       = int'(newest_d) - int'(k_d);
        if (rd_diff < 0) rd_diff = rd_diff + TAPS;
        fold_step     = int'(k_d) / ADD_LAT + 1;
        case (state_d)
            S_MUL: begin
                issue_d      = 1'b1;
                opcode_d     = OP_MUL;
                a_sel_d      = A_DMEM;
                b_sel_d      = B_CMEM;
                dmem_raddr_d = DW'(rd_diff);
                cmem_raddr_d = DW'(k_d);
            end
            S_ACC: begin
                issue_d      = 1'b1;
                opcode_d     = OP_ADD;
                a_sel_d      = A_REGF;
                b_sel_d      = (k_d < KW'(ADD_LAT)) ? B_ZERO : B_SELF;
                regf_raddr_d = AW'(k_d);
            end
            S_SPILL: begin
                spill_we_d    = 1'b1;
                spill_waddr_d = AW'(TAPS + int'(k_d));
                acc_we_d      = (k_d == '0);
            end
            S_FOLD: begin
                // One fold step every ADD_LAT cycles so each step consumes
                // the previous step's result straight off the ALU output.
                if (int'(k_d) % ADD_LAT == 0) begin
                    issue_d      = 1'b1;
                    opcode_d     = OP_ADD;
                    a_sel_d      = A_REGF;
                    b_sel_d      = (fold_step == 1) ? B_ACC : B_SELF;
                    regf_raddr_d = AW'(TAPS + fold_step);
                end
            end
            S_NORM: begin
                if (k_d == '0) begin
                    issue_d  = 1'b1;
                    opcode_d = OP_NORM;
                    a_sel_d  = A_SELF;
                    b_sel_d  = B_ZERO;
                end
                if (k_d == KW'(ADD_LAT)) begin
                    dout_valid_d = 1'b1;
                    acc_we_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            wr_ptr_q      <= '0;
            newest_q      <= '0;
            overrun_q     <= 1'b0;
            coef_err_q    <= 1'b0;
            issue_q       <= 1'b0;
            opcode_q      <= '0;
            a_sel_q       <= '0;
            b_sel_q       <= '0;
            dmem_raddr_q  <= '0;
            cmem_raddr_q  <= '0;
            regf_raddr_q  <= '0;
            spill_we_q    <= 1'b0;
            spill_waddr_q <= '0;
            acc_we_q      <= 1'b0;
            dout_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            wr_ptr_q      <= wr_ptr_d;
            newest_q      <= newest_d;
            overrun_q     <= overrun_d;
            coef_err_q    <= coef_err_d;
            issue_q       <= issue_d;
            opcode_q      <= opcode_d;
            a_sel_q       <= a_sel_d;
            b_sel_q       <= b_sel_d;
            dmem_raddr_q  <= dmem_raddr_d;
            cmem_raddr_q  <= cmem_raddr_d;
            regf_raddr_q  <= regf_raddr_d;
            spill_we_q    <= spill_we_d;
            spill_waddr_q <= spill_waddr_d;
            acc_we_q      <= acc_we_d;
            dout_valid_q  <= dout_valid_d;
        end
    end

    fir_tag_pipe #(
        .DEPTH(MUL_LAT),
        .W    (AW)
    ) u_tag_pipe (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .in_valid (issue_q && (opcode_q == OP_MUL)),
        .in_addr  (AW'(cmem_raddr_q)),
        .out_valid(tag_valid),
        .out_addr (tag_addr)
    );

    // Memory write strobes answer a request in the cycle it is presented.
    always_comb begin
        bus.dmem_we    = idle && bus.sample_valid;
        bus.dmem_waddr = bus.dmem_we ? wr_ptr_q : '0;
        bus.cmem_we    = idle && bus.cload;
        bus.cmem_waddr = bus.cmem_we ? bus.caddr : '0;
    end

    assign bus.dmem_raddr = dmem_raddr_q;
    assign bus.cmem_raddr = cmem_raddr_q;
    assign bus.regf_we    = tag_valid || spill_we_q;
    assign bus.regf_waddr = tag_valid ? tag_addr : spill_waddr_q;
    assign bus.regf_raddr = regf_raddr_q;
    assign bus.acc_we     = acc_we_q;
    assign bus.alu_issue  = issue_q;
    assign bus.alu_opcode = opcode_q;
    assign bus.alu_a_sel  = a_sel_q;
    assign bus.alu_b_sel  = b_sel_q;
    assign bus.busy       = !idle;
    assign bus.dout_valid = dout_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.coef_err   = coef_err_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench: default configuration (64/4/5) plus a small 7/2/3 instance.
module tb_fir_mac_sequencer;
    logic clk_fast = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_fast = ~clk_fast;

    fir_mac_sequencer_if #(.TAPS(64), .ADD_LAT(5)) d_if ();
    fir_mac_sequencer_if #(.TAPS(7),  .ADD_LAT(3)) s_if ();

    fir_mac_sequencer #(.TAPS(64), .MUL_LAT(4), .ADD_LAT(5)) u_dut_d (
        .clk_fast(clk_fast), .rst_n(rst_n), .bus(d_if.master));
    fir_mac_sequencer #(.TAPS(7), .MUL_LAT(2), .ADD_LAT(3)) u_dut_s (
        .clk_fast(clk_fast), .rst_n(rst_n), .bus(s_if.master));

    task automatic apply_reset();
        rst_n = 1'b0;
        d_if.sample_valid = 0; d_if.cload = 0; d_if.caddr = '0; d_if.ovr_clr = 0;
        s_if.sample_valid = 0; s_if.cload = 0; s_if.caddr = '0; s_if.ovr_clr = 0;
        repeat (3) @(negedge clk_fast);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] ctl_d, ctl_s;
        logic [39:0] adr_d;
        apply_reset();
        #1;
        ctl_d = {d_if.busy, d_if.alu_issue, d_if.regf_we, d_if.acc_we,
                 d_if.dout_valid, d_if.overrun, d_if.coef_err, d_if.dmem_we};
        adr_d = {d_if.dmem_raddr, d_if.cmem_raddr, d_if.regf_raddr, d_if.regf_waddr,
                 d_if.alu_opcode, d_if.alu_a_sel, d_if.alu_b_sel, d_if.cmem_we,
                 d_if.dmem_waddr, 1'b0};
        ctl_s = {s_if.busy, s_if.alu_issue, s_if.regf_we, s_if.acc_we,
                 s_if.dout_valid, s_if.overrun, s_if.coef_err, s_if.dmem_we};
        n_cmp++;
        if (ctl_d !== 8'h00) begin
            n_bad++; $display("FAIL reset_ctl_default: got %b want 00000000", ctl_d);
        end
        n_cmp++;
        if (adr_d !== 40'h0) begin
            n_bad++; $display("FAIL reset_addr_default: got %h want 0", adr_d);
        end
        n_cmp++;
        if (ctl_s !== 8'h00) begin
            n_bad++; $display("FAIL reset_ctl_small: got %b want 00000000", ctl_s);
        end
    endtask

    task automatic test_single();
        logic [5:0] exp_r;
        apply_reset();
        @(negedge clk_fast);
        d_if.sample_valid = 1'b1;
        #1;
        n_cmp++;
        if (d_if.dmem_we !== 1'b1 || d_if.dmem_waddr !== 6'd0) begin
            n_bad++;
            $display("FAIL single_accept: we=%b waddr=%0d want we=1 waddr=0",
                     d_if.dmem_we, d_if.dmem_waddr);
        end
        for (int i = 1; i <= 164; i++) begin
            @(negedge clk_fast);
            d_if.sample_valid = 1'b0;
            if (i <= 64) begin
                exp_r = 6'((64 - (i - 1)) % 64);
                n_cmp++;
                if (d_if.dmem_raddr !== exp_r || d_if.cmem_raddr !== 6'(i - 1) ||
                    d_if.alu_issue !== 1'b1 || d_if.alu_opcode !== 2'b10 ||
                    d_if.alu_a_sel !== 2'd0 || d_if.alu_b_sel !== 2'd0) begin
                    n_bad++;
                    $display("FAIL mul_k%0d: draddr=%0d craddr=%0d iss=%b op=%b a=%0d b=%0d want draddr=%0d craddr=%0d iss=1 op=10 a=0 b=0",
                             i - 1, d_if.dmem_raddr, d_if.cmem_raddr, d_if.alu_issue,
                             d_if.alu_opcode, d_if.alu_a_sel, d_if.alu_b_sel, exp_r, i - 1);
                end
            end
            n_cmp++;
            if (d_if.dout_valid !== (i == 163) || d_if.busy !== (i <= 163)) begin
                n_bad++;
                $display("FAIL single_cycle%0d: dout=%b busy=%b want dout=%b busy=%b",
                         i, d_if.dout_valid, d_if.busy, i == 163, i <= 163);
            end
            if (i == 133 || i == 137) begin
                n_cmp++;
                if (d_if.regf_we !== 1'b1 || d_if.regf_waddr !== 7'(64 + i - 133) ||
                    d_if.acc_we !== (i == 133) || d_if.alu_issue !== 1'b0) begin
                    n_bad++;
                    $display("FAIL spill_%0d: we=%b waddr=%0d acc_we=%b iss=%b want we=1 waddr=%0d acc_we=%b iss=0",
                             i, d_if.regf_we, d_if.regf_waddr, d_if.acc_we, d_if.alu_issue,
                             64 + i - 133, i == 133);
                end
            end
            if (i == 138 || i == 143) begin
                n_cmp++;
                if (d_if.alu_issue !== 1'b1 || d_if.alu_opcode !== 2'b11 ||
                    d_if.alu_a_sel !== 2'd1 || d_if.regf_raddr !== 7'(i == 138 ? 65 : 66) ||
                    d_if.alu_b_sel !== (i == 138 ? 2'd2 : 2'd1)) begin
                    n_bad++;
                    $display("FAIL fold_%0d: iss=%b op=%b a=%0d raddr=%0d b=%0d want iss=1 op=11 a=1 raddr=%0d b=%0d",
                             i, d_if.alu_issue, d_if.alu_opcode, d_if.alu_a_sel,
                             d_if.regf_raddr, d_if.alu_b_sel, i == 138 ? 65 : 66, i == 138 ? 2 : 1);
                end
            end
            if (i == 139) begin
                n_cmp++;
                if (d_if.alu_issue !== 1'b0 || d_if.alu_opcode !== 2'b00) begin
                    n_bad++;
                    $display("FAIL fold_gap: iss=%b op=%b want iss=0 op=00", d_if.alu_issue, d_if.alu_opcode);
                end
            end
            if (i == 158) begin
                n_cmp++;
                if (d_if.alu_issue !== 1'b1 || d_if.alu_opcode !== 2'b00 ||
                    d_if.alu_a_sel !== 2'd2 || d_if.alu_b_sel !== 2'd3) begin
                    n_bad++;
                    $display("FAIL norm_issue: iss=%b op=%b a=%0d b=%0d want iss=1 op=00 a=2 b=3",
                             d_if.alu_issue, d_if.alu_opcode, d_if.alu_a_sel, d_if.alu_b_sel);
                end
            end
            if (i == 163) begin
                n_cmp++;
                if (d_if.acc_we !== 1'b1) begin
                    n_bad++; $display("FAIL norm_acc_we: got %b want 1", d_if.acc_we);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            @(negedge clk_fast);
            d_if.sample_valid = 1'b1;
            #1;
            n_cmp++;
            if (d_if.dmem_we !== 1'b1 || d_if.dmem_waddr !== 6'(p)) begin
                n_bad++;
                $display("FAIL b2b_accept%0d: we=%b waddr=%0d want we=1 waddr=%0d",
                         p, d_if.dmem_we, d_if.dmem_waddr, p);
            end
            for (int i = 1; i <= 163; i++) begin
                @(negedge clk_fast);
                d_if.sample_valid = 1'b0;
                if (i == 1) begin
                    n_cmp++;
                    if (d_if.dmem_raddr !== 6'(p)) begin
                        n_bad++;
                        $display("FAIL b2b_first_raddr%0d: got %0d want %0d", p, d_if.dmem_raddr, p);
                    end
                end
            end
            n_cmp++;
            if (d_if.dout_valid !== 1'b1) begin
                n_bad++; $display("FAIL b2b_dout%0d: got %b want 1", p, d_if.dout_valid);
            end
        end
        n_cmp++;
        if (d_if.overrun !== 1'b0) begin
            n_bad++; $display("FAIL b2b_overrun: got %b want 0", d_if.overrun);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        @(negedge clk_fast);
        d_if.sample_valid = 1'b1;
        for (int i = 1; i <= 163; i++) begin
            @(negedge clk_fast);
            d_if.sample_valid = 1'b0;
            d_if.ovr_clr = 1'b0;
            if (i == 50) begin
                // set and clear together: the set must win
                d_if.sample_valid = 1'b1;
                d_if.ovr_clr = 1'b1;
                #1;
                n_cmp++;
                if (d_if.dmem_we !== 1'b0) begin
                    n_bad++; $display("FAIL ovr_no_write: dmem_we=%b want 0", d_if.dmem_we);
                end
            end
            if (i == 51 || i == 163) begin
                n_cmp++;
                if (d_if.overrun !== 1'b1) begin
                    n_bad++; $display("FAIL ovr_set_c%0d: got %b want 1", i, d_if.overrun);
                end
            end
        end
        n_cmp++;
        if (d_if.dout_valid !== 1'b1) begin
            n_bad++; $display("FAIL ovr_dout: got %b want 1", d_if.dout_valid);
        end
        @(negedge clk_fast);
        d_if.ovr_clr = 1'b1;
        @(negedge clk_fast);
        d_if.ovr_clr = 1'b0;
        n_cmp++;
        if (d_if.overrun !== 1'b0) begin
            n_bad++; $display("FAIL ovr_clear: got %b want 0", d_if.overrun);
        end
        d_if.sample_valid = 1'b1;
        #1;
        n_cmp++;
        if (d_if.dmem_we !== 1'b1 || d_if.dmem_waddr !== 6'd1) begin
            n_bad++;
            $display("FAIL ovr_next_ptr: we=%b waddr=%0d want we=1 waddr=1", d_if.dmem_we, d_if.dmem_waddr);
        end
        @(negedge clk_fast);
        d_if.sample_valid = 1'b0;
    endtask

    task automatic test_cload();
        apply_reset();
        @(negedge clk_fast);
        d_if.sample_valid = 1'b1;
        d_if.cload = 1'b1;
        d_if.caddr = 6'd5;
        #1;
        n_cmp++;
        if (d_if.cmem_we !== 1'b1 || d_if.cmem_waddr !== 6'd5 || d_if.dmem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL cload_idle: cwe=%b cwaddr=%0d dwe=%b want cwe=1 cwaddr=5 dwe=1",
                     d_if.cmem_we, d_if.cmem_waddr, d_if.dmem_we);
        end
        for (int i = 1; i <= 163; i++) begin
            @(negedge clk_fast);
            d_if.sample_valid = 1'b0;
            d_if.cload = 1'b0;
            if (i == 69 || i == 73 || i == 74) begin
                n_cmp++;
                if (d_if.alu_issue !== 1'b1 || d_if.alu_opcode !== 2'b11 || d_if.alu_a_sel !== 2'd1 ||
                    d_if.regf_raddr !== 7'(i - 69) || d_if.alu_b_sel !== (i == 74 ? 2'd1 : 2'd3)) begin
                    n_bad++;
                    $display("FAIL acc_k%0d: iss=%b op=%b a=%0d raddr=%0d b=%0d want iss=1 op=11 a=1 raddr=%0d b=%0d",
                             i - 69, d_if.alu_issue, d_if.alu_opcode, d_if.alu_a_sel,
                             d_if.regf_raddr, d_if.alu_b_sel, i - 69, i == 74 ? 1 : 3);
                end
            end
            if (i == 80) begin
                d_if.cload = 1'b1;
                d_if.caddr = 6'd9;
                #1;
                n_cmp++;
                if (d_if.cmem_we !== 1'b0) begin
                    n_bad++; $display("FAIL cload_busy_we: got %b want 0", d_if.cmem_we);
                end
            end
            if (i == 81) begin
                n_cmp++;
                if (d_if.coef_err !== 1'b1 || d_if.overrun !== 1'b0) begin
                    n_bad++;
                    $display("FAIL coef_err: coef_err=%b overrun=%b want 1 and 0", d_if.coef_err, d_if.overrun);
                end
            end
        end
        n_cmp++;
        if (d_if.dout_valid !== 1'b1 || d_if.coef_err !== 1'b1) begin
            n_bad++;
            $display("FAIL cload_end: dout=%b coef_err=%b want 1 and 1", d_if.dout_valid, d_if.coef_err);
        end
    endtask

    task automatic test_small();
        logic       exp_we, exp_iss;
        logic [3:0] exp_wa;
        apply_reset();
        @(negedge clk_fast);
        s_if.sample_valid = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_fast);
            s_if.sample_valid = 1'b0;
            exp_we  = (i >= 3 && i <= 9) || (i >= 17 && i <= 19);
            exp_wa  = (i <= 9) ? 4'(i - 3) : 4'(i - 10);
            exp_iss = (i >= 1 && i <= 7) || (i >= 10 && i <= 16) || i == 20 || i == 23 || i == 26;
            n_cmp++;
            if (s_if.regf_we !== exp_we || (exp_we && s_if.regf_waddr !== exp_wa) ||
                s_if.alu_issue !== exp_iss || s_if.dout_valid !== (i == 29)) begin
                n_bad++;
                $display("FAIL small_c%0d: we=%b waddr=%0d iss=%b dout=%b want we=%b waddr=%0d iss=%b dout=%b",
                         i, s_if.regf_we, s_if.regf_waddr, s_if.alu_issue, s_if.dout_valid,
                         exp_we, exp_wa, exp_iss, i == 29);
            end
            if (i == 2) begin
                n_cmp++;
                if (s_if.dmem_raddr !== 3'd6) begin
                    n_bad++; $display("FAIL small_wrap: raddr=%0d want 6", s_if.dmem_raddr);
                end
            end
            if (i == 12 || i == 13) begin
                n_cmp++;
                if (s_if.alu_b_sel !== (i == 12 ? 2'd3 : 2'd1)) begin
                    n_bad++; $display("FAIL small_acc_b%0d: got %0d want %0d", i, s_if.alu_b_sel, i == 12 ? 3 : 1);
                end
            end
            if (i == 20 || i == 23) begin
                n_cmp++;
                if (s_if.regf_raddr !== (i == 20 ? 4'd8 : 4'd9) || s_if.alu_b_sel !== (i == 20 ? 2'd2 : 2'd1)) begin
                    n_bad++;
                    $display("FAIL small_fold%0d: raddr=%0d b=%0d want raddr=%0d b=%0d",
                             i, s_if.regf_raddr, s_if.alu_b_sel, i == 20 ? 8 : 9, i == 20 ? 2 : 1);
                end
            end
        end
        for (int p = 1; p <= 7; p++) begin
            s_if.sample_valid = 1'b1;
            #1;
            n_cmp++;
            if (s_if.dmem_we !== 1'b1 || s_if.dmem_waddr !== 3'(p % 7)) begin
                n_bad++;
                $display("FAIL small_ptr%0d: we=%b waddr=%0d want we=1 waddr=%0d",
                         p, s_if.dmem_we, s_if.dmem_waddr, p % 7);
            end
            for (int i = 1; i <= 29; i++) begin
                @(negedge clk_fast);
                s_if.sample_valid = 1'b0;
                if (i == 2) begin
                    n_cmp++;
                    if (s_if.dmem_raddr !== 3'((p + 6) % 7)) begin
                        n_bad++;
                        $display("FAIL small_raddr%0d: got %0d want %0d", p, s_if.dmem_raddr, (p + 6) % 7);
                    end
                end
            end
            @(negedge clk_fast);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] ctl;
        apply_reset();
        @(negedge clk_fast);
        d_if.sample_valid = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_fast);
            d_if.sample_valid = 1'b0;
            if (i == 99) begin
                n_cmp++;
                if (d_if.alu_issue !== 1'b1 || d_if.busy !== 1'b1) begin
                    n_bad++; $display("FAIL mid_pre: iss=%b busy=%b want 1 1", d_if.alu_issue, d_if.busy);
                end
            end
        end
        rst_n = 1'b0;
        #1;
        ctl = {d_if.busy, d_if.alu_issue, d_if.alu_opcode, d_if.alu_a_sel, d_if.alu_b_sel,
               d_if.regf_we, d_if.acc_we, d_if.dout_valid, d_if.overrun, d_if.coef_err, d_if.dmem_we};
        n_cmp++;
        if (ctl !== 14'h0 || d_if.regf_raddr !== 7'd0 || d_if.dmem_raddr !== 6'd0) begin
            n_bad++;
            $display("FAIL mid_reset_out: ctl=%b rraddr=%0d draddr=%0d want all 0",
                     ctl, d_if.regf_raddr, d_if.dmem_raddr);
        end
        @(negedge clk_fast);
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_fast);
            n_cmp++;
            if (d_if.dout_valid !== 1'b0 || d_if.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_quiet%0d: dout=%b busy=%b want 0 0", i, d_if.dout_valid, d_if.busy);
            end
        end
        d_if.sample_valid = 1'b1;
        #1;
        n_cmp++;
        if (d_if.dmem_we !== 1'b1 || d_if.dmem_waddr !== 6'd0) begin
            n_bad++;
            $display("FAIL mid_ptr: we=%b waddr=%0d want we=1 waddr=0", d_if.dmem_we, d_if.dmem_waddr);
        end
        @(negedge clk_fast);
        d_if.sample_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_cload();
        test_small();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Parametrised control sequencer for the time-multiplexed FP FIR filter. It replaces gated-clock sequencing with single-clock enables. It runs one multiply pass and one accumulate pass over TAPS taps for each accepted sample, then folds the pipelined partial sums, normalises, and pulses `dout_valid`. It drives addresses, write enables and mux selects for DMEM (circular sample buffer), CMEM (coefficients), REGF (product and partial-sum file), the accumulator register and the shared FPALU.

## Interface
- `TAPS`, 64: filter length; ≥ ADD_LAT; need not be a power of two.
- `MUL_LAT`, 4: FPALU multiply latency, ≥1.
- `ADD_LAT`, 5: FPALU add/normalise latency, ≥1.
- `AW`, $clog2(TAPS+ADD_LAT): REGF address width; DMEM/CMEM use $clog2(TAPS).

Ports:
- `clk_fast` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe, already synchronised to clk_fast.
- `cload` in 1: coefficient write request; `caddr` in $clog2(TAPS): target address.
- `ovr_clr` in 1: clears the sticky flags.
- `dmem_we` out 1; `dmem_waddr`, `dmem_raddr` out $clog2(TAPS).
- `cmem_we` out 1; `cmem_waddr`, `cmem_raddr` out $clog2(TAPS).
- `regf_we` out 1; `regf_waddr`, `regf_raddr` out AW.
- `acc_we` out 1: accumulator register captures the ALU output.
- `alu_issue` out 1: the ALU input is a valid operation this cycle.
- `alu_opcode` out 2: MUL=2'b10, ADD=2'b11, NORM=2'b00.
- `alu_a_sel` out 2: DMEM=0, REGF=1, SELF=2, ACC=3.
- `alu_b_sel` out 2: CMEM=0, SELF=1, ACC=2, ZERO=3.
- `busy` out 1; `dout_valid` out 1; `overrun` out 1; `coef_err` out 1.

## Operation
- States: IDLE, MUL, MDRAIN, ACC, SPILL, FOLD, NORM. Counter `k` restarts at 0 on every state entry.
- IDLE: `busy`=0.
  - `sample_valid` asserts `dmem_we` with `dmem_waddr`=wr_ptr and latches newest=wr_ptr; wr_ptr advances mod TAPS; next state MUL.
  - `cload` asserts `cmem_we` with `cmem_waddr`=`caddr` in the same cycle. Both requests together are both accepted.
- MUL, TAPS cycles: issue MUL with a=DMEM, b=CMEM, `dmem_raddr`=(newest−k) mod TAPS, `cmem_raddr`=k.
- Product tagging: the result of issue k is written at issue+MUL_LAT with `regf_waddr`=k. The write tags run through a MUL_LAT-deep pipe.
- MDRAIN, MUL_LAT cycles: no issue; remaining products are written.
- ACC, TAPS cycles: issue ADD with a=REGF, `regf_raddr`=k; b=ZERO for k<ADD_LAT, otherwise SELF. This forms ADD_LAT interleaved partial sums.
- SPILL, ADD_LAT cycles, index j: no issue; `regf_we` with `regf_waddr`=TAPS+j. In j=0, `acc_we` is also asserted.
- FOLD, (ADD_LAT−1)·ADD_LAT cycles: step s=1..ADD_LAT−1 issues at FOLD cycle (s−1)·ADD_LAT: ADD, a=REGF[TAPS+s], b=ACC when s=1, otherwise SELF.
- NORM: issue NORM with a=SELF, b=ZERO in cycle 0. Wait ADD_LAT cycles, then `dout_valid`=1 and `acc_we`=1 for one cycle; next state IDLE.
- Outside issue cycles: `alu_issue`=0 and opcode/sels are 0.
- `sample_valid` when not IDLE: sample dropped, no DMEM write, `overrun` set.
- `cload` when not IDLE: dropped, `coef_err` set.
- Flags are sticky until `ovr_clr` or reset. Set wins over a simultaneous clear.

## Timing
- Reset: state IDLE, wr_ptr=0, every output 0. DMEM/CMEM/REGF contents are untouched.
- Reset mid-pass aborts immediately; no `dout_valid` follows.
- `sample_valid` in cycle T gives `dout_valid` at T+1+2·TAPS+MUL_LAT+ADD_LAT·(ADD_LAT+1). With defaults that is T+163.
- `busy`=1 from T+1 through the `dout_valid` cycle. A new sample is accepted from the following cycle (T+164).
- ADD_LAT=1: FOLD takes 0 cycles. TAPS=ADD_LAT: ACC issues with b=ZERO only.
- Address wrap: (newest−k) wraps modulo TAPS, also for non-power-of-two TAPS.

## Structure
- Package `fir_pkg`: opcode constants, a_sel/b_sel encodings, state enum.
- Sub-module `fir_tag_pipe`: a parametrised delay line (valid+address) used for the MUL_LAT product-write tags.

## Test plan
- Reset, then one `sample_valid`: `dmem_waddr`=0; MUL k=0..63 gives `dmem_raddr` 0,63,62,…,1 and `cmem_raddr` 0..63; `dout_valid` exactly at T+163, one cycle wide.
- Three samples spaced 164 cycles apart: accepted `dmem_waddr` 0,1,2; third pass starts MUL with `dmem_raddr`=2 and `overrun` stays 0.
- `sample_valid` at T+50: no `dmem_we`, `overrun`=1, `dout_valid` still at T+163; then `ovr_clr` gives `overrun`=0.
- `cload` with `caddr`=5 together with `sample_valid` in IDLE: both writes occur; `cload` during ACC gives `coef_err`=1 and no `cmem_we`.
- TAPS=7, MUL_LAT=2, ADD_LAT=3: `regf_we` addresses 0..6, then 7..9 in SPILL; FOLD issues at offsets 0 and 3; `dout_valid` at T+1+14+2+12=T+29.
- `rst_n` low at T+100: all outputs 0 asynchronously; no `dout_valid`; next sample is written at `dmem_waddr`=0.
